// File: rtl/midi_rx_fifo.sv
// MIDI IN UART receiver: synchronised line, 3-sample majority vote per bit,
// receive FIFO with sticky overrun / framing-error flags and a level interrupt.
module midi_rx_fifo #(
    parameter int CLKS_PER_BIT = 256,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4,
    localparam int MID = CLKS_PER_BIT / 2,
    localparam int CW  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 midi_in,
    input  logic                 bus_rd,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] bus_dat,
    output logic                 irq,
    output logic [CW-1:0]        rx_count,
    output logic                 overrun,
    output logic                 frame_err
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 2);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] T_A         = TW'(MID - 1);
    localparam logic [TW-1:0] T_B         = TW'(MID);
    localparam logic [TW-1:0] T_C         = TW'(MID + 1);
    localparam logic [TW-1:0] T_LAST      = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] B_LAST_DATA = BW'(DATA_BITS);
    localparam logic [CW-1:0] C_FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and start-edge detection
    // ------------------------------------------------------------------
    logic [1:0] sync_reg;
    logic [1:0] vld_reg;
    logic       line_prev_reg;
    logic       armed_reg;
    logic       line_s;
    logic       start_edge;

    assign line_s = sync_reg[1];

    // vld_reg tracks when sync_reg holds real line samples after reset, so a
    // line that is already low coming out of reset must first be seen high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg      <= 2'b11;
            vld_reg       <= 2'b00;
            line_prev_reg <= 1'b1;
            armed_reg     <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], midi_in};
            vld_reg       <= {vld_reg[0], 1'b1};
            line_prev_reg <= line_s;
            armed_reg     <= armed_reg | (vld_reg[1] & line_s);
        end
    end

    assign start_edge = armed_reg & line_prev_reg & ~line_s;

    // ------------------------------------------------------------------
    // Bit timer, majority vote and receive state machine
    // ------------------------------------------------------------------
    state_t               state_reg;
    logic [TW-1:0]        timer_reg;
    logic [BW-1:0]        bit_idx_reg;
    logic                 samp_a_reg;
    logic                 samp_b_reg;
    logic [DATA_BITS-1:0] rx_sr_reg;

    logic vote_edge;
    logic timer_wrap;
    logic vote;
    logic push_req;
    logic ferr_set;

    // The third sample is the live line at timer MID+1, so the decision lands
    // on the edge where the timer enters MID+2.
    assign vote_edge  = (timer_reg == T_C);
    assign timer_wrap = (timer_reg == T_LAST);
    assign vote       = (samp_a_reg & samp_b_reg) | ((samp_a_reg ^ samp_b_reg) & line_s);
    assign push_req   = (state_reg == STOP) & vote_edge & vote;
    assign ferr_set   = (state_reg == STOP) & vote_edge & ~vote;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            samp_a_reg  <= 1'b1;
            samp_b_reg  <= 1'b1;
            rx_sr_reg   <= '0;
        end else begin
            if (state_reg != IDLE) begin
                timer_reg <= timer_wrap ? '0 : timer_reg + TW'(1);
                if (timer_reg == T_A) samp_a_reg <= line_s;
                if (timer_reg == T_B) samp_b_reg <= line_s;
            end
            case (state_reg)
                IDLE: begin
                    timer_reg   <= '0;
                    bit_idx_reg <= '0;
                    if (start_edge) state_reg <= START;
                end
                START: begin
                    if (vote_edge && vote) begin
                        state_reg <= IDLE;
                        timer_reg <= '0;
                    end else if (timer_wrap) begin
                        state_reg   <= DATA;
                        bit_idx_reg <= BW'(1);
                    end
                end
                DATA: begin
                    if (vote_edge) rx_sr_reg <= {vote, rx_sr_reg[DATA_BITS-1:1]};
                    if (timer_wrap) begin
                        bit_idx_reg <= bit_idx_reg + BW'(1);
                        if (bit_idx_reg == B_LAST_DATA) state_reg <= STOP;
                    end
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is caught.
                    if (vote_edge) begin
                        state_reg <= IDLE;
                        timer_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr_reg;
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_next;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic [DATA_BITS-1:0] bus_dat_reg;
    logic [DATA_BITS-1:0] bus_dat_next;
    logic                 irq_reg;
    logic                 overrun_reg;
    logic                 frame_err_reg;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push;
    logic ovr_set;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == C_FULL);
    assign pop        = bus_rd & ~fifo_empty;
    assign push       = push_req & (~fifo_full | pop);
    assign ovr_set    = push_req & fifo_full & ~pop;

    // Registered head: when the new head is the entry being written this
    // cycle, bypass the array and take the incoming byte directly.
    always_comb begin
        rd_ptr_next  = rd_ptr_reg + PW'(pop);
        count_next   = count_reg + CW'(push) - CW'(pop);
        bus_dat_next = '0;
        if (count_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) bus_dat_next = rx_sr_reg;
            else                                     bus_dat_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= rx_sr_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            irq_reg       <= 1'b0;
            bus_dat_reg   <= '0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            rd_ptr_reg    <= rd_ptr_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            count_reg     <= count_next;
            irq_reg       <= (count_next != '0);
            bus_dat_reg   <= bus_dat_next;
            // A set in the same cycle as err_clr wins.
            overrun_reg   <= ovr_set | (overrun_reg & ~err_clr);
            frame_err_reg <= ferr_set | (frame_err_reg & ~err_clr);
        end
    end

    assign bus_dat   = bus_dat_reg;
    assign irq       = irq_reg;
    assign rx_count  = count_reg;
    assign overrun   = overrun_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: doc/midi_rx_fifo.md
# midi_rx_fifo

Parametrised MIDI input UART receiver with a receive FIFO, the successor to the single-byte MIDI receiver. It sits between a MIDI IN opto-isolator pin and the router's bus-side logic. It oversamples the serial line with a configurable bit period and uses a 3-sample majority vote per bit. Received bytes are queued in a FIFO, framing and overrun errors are reported as sticky flags, and a level interrupt is raised while data is pending.

## Interface
- CLKS_PER_BIT, 256: clk cycles per serial bit; 8 MHz / 31250 baud; legal range >= 8.
- DATA_BITS, 8: data bits per frame, LSB first.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, >= 2.
- MID (derived, not overridable) = CLKS_PER_BIT/2.
- CW (derived) = log2(FIFO_DEPTH)+1.

- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- midi_in  in  1  asynchronous serial line; idle high.
- bus_rd  in  1  one-cycle pop strobe; ignored when FIFO empty.
- err_clr  in  1  clears overrun and frame_err.
- bus_dat  out  DATA_BITS  FIFO head entry; 0 when empty.
- irq  out  1  high while FIFO non-empty (level).
- rx_count  out  CW  number of bytes in FIFO.
- overrun  out  1  sticky; a byte was dropped because the FIFO was full.
- frame_err  out  1  sticky; stop bit voted 0.

## Operation
- **Synchroniser:** midi_in passes through a 2-flop synchroniser; both flops reset to 1. The start edge is a synchronised 1→0 transition, detected only in IDLE.
- **Bit timer:** counts 0..CLKS_PER_BIT-1, then wraps. The bit index b counts 0 = start, 1..DATA_BITS = data, DATA_BITS+1 = stop.
  - On start-edge detection, the timer and b are set to 0.
  - The timer holds at 0 in IDLE.
- **Sampling:** the synchronised line is captured at timer values MID-1, MID and MID+1.
  - The vote is evaluated at timer MID+2: vote = ab + (a xor b)c.
- **States:**
  - IDLE: wait for the start edge, then go to START.
  - START: if the vote is 1 (glitch), go to IDLE with no push and no error. If the vote is 0, go to DATA at the timer wrap.
  - DATA: the vote is shifted in LSB first at each bit's MID+2. After bit DATA_BITS wraps, go to STOP.
  - STOP: at MID+2, if the vote is 1, push the byte. If the vote is 0, discard the byte and set frame_err. In both cases go to IDLE in the same cycle, half a bit early, so the receiver can resync to a back-to-back start bit.
- **FIFO:**
  - Push when not full increments rx_count.
  - Push when full drops the new byte, sets overrun, and leaves the FIFO contents unchanged.
  - bus_rd when non-empty advances the head; bus_rd when empty does nothing.
  - Simultaneous push and pop: both take effect and rx_count is unchanged. This also applies when full (no overrun) and when empty with a push (the pushed byte is not popped that cycle).
  - Pointers wrap modulo FIFO_DEPTH.
- **Sticky flags:** err_clr clears both flags. If a set condition and err_clr occur in the same cycle, the set wins.
- **Reset (including mid-frame):**
  - State goes to IDLE and the FIFO is emptied.
  - irq=0, rx_count=0, bus_dat=0, overrun=0, frame_err=0.
  - If the line is low after reset, no frame starts until it goes high and then falls.

## Timing
- Start-edge detection occurs 2 clk edges after the first edge sampling midi_in low. Timer=0 follows 1 edge later.
- irq and rx_count update exactly (DATA_BITS+1)·CLKS_PER_BIT + MID + 4 edges after the first edge sampling midi_in low; 2436 cycles at defaults.
- frame_err rises at the same edge a valid byte would have been pushed.
- bus_dat reflects the new head, and irq/rx_count reflect the pop, on the edge after bus_rd.
- Back-to-back frames with zero idle between stop and next start are received without loss.
- Throughput: one byte per (DATA_BITS+2)·CLKS_PER_BIT cycles.

## Test plan
- Defaults; send frame 0x90 (LSB first, one stop). Required: irq rises at cycle 2436 after the start fall, rx_count=1, bus_dat=0x90. Pulse bus_rd: the next cycle shows irq=0, rx_count=0, bus_dat=0.
- Send 0x90, 0x3C, 0x7F back-to-back with no idle gap. Required: rx_count=3; successive pops read 0x90, 0x3C, 0x7F; no error flags.
- A 40-cycle low glitch on an idle line produces no push and no frame_err. A single-sample 1-cycle spike inside data bit 3 of 0x00 still yields 0x00.
- Hold the stop bit low on frame 0x45. Required: frame_err=1, rx_count unchanged. err_clr in the same cycle as the stop vote leaves frame_err=1; err_clr later clears it.
- FIFO_DEPTH=4: send 5 bytes without reading. Required: rx_count=4, overrun=1, and pops return the first 4 bytes. Repeat with bus_rd coinciding with the 5th push: no overrun, and the 5th byte is retained.
- Assert reset at data bit 4 with 2 bytes queued and midi_in held low. Required: all outputs 0 next cycle; no frame until midi_in rises and then falls; the next frame is received correctly.
